// File: rtl/fact_pkg.sv
// ---------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the inverse-factorial search engine.
//   FACT_MAX_N : largest n searched (8! = 40320 is the largest 16-bit factorial)
//   VAL_W      : operand width
//   N_W        : width of the reported n
//   PROD_W     : width of the running product; wide enough that acc*(k+1)
//                never wraps, even for acc = 8! and k = 8
//   state_t    : controller states
// ---------------------------------------------------------------------------
package fact_pkg;

    localparam int FACT_MAX_N = 8;
    localparam int VAL_W      = 16;
    localparam int N_W        = 4;
    localparam int PROD_W     = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fact_step.sv
// ---------------------------------------------------------------------------
// fact_step
// One multiply-compare step of the factorial search (purely combinational).
// Ports:
//   acc     in  : current factorial k!
//   k       in  : current n candidate
//   value   in  : registered operand
//   prod    out : acc*(k+1), full width
//   advance out : high when (k+1)! still fits under value and k < MAX_N
// ---------------------------------------------------------------------------
module fact_step
    import fact_pkg::*;
#(
    parameter int MAX_N = FACT_MAX_N
) (
    input  logic [PROD_W-1:0] acc,
    input  logic [N_W-1:0]    k,
    input  logic [VAL_W-1:0]  value,
    output logic [PROD_W-1:0] prod,
    output logic              advance
);

    // The product is formed at full width so the compare sees the true
    // value; a truncated product could wrap below value and advance falsely.
    always_comb begin
        prod    = acc * (PROD_W'(k) + PROD_W'(1));
        advance = (prod <= PROD_W'(value)) && (k < N_W'(MAX_N));
    end

endmodule

// File: rtl/inverse_factorial.sv
// ---------------------------------------------------------------------------
// inverse_factorial
// Finds the largest n in 1..MAX_N with n! <= value, one multiply per cycle.
// Ports:
//   clk    in  : clock, rising edge
//   rst_n  in  : synchronous active-low reset
//   start  in  : request, sampled only in IDLE
//   value  in  : operand, captured when start is accepted
//   busy   out : high while searching (CALC)
//   done   out : one-cycle pulse in the DONE state
//   n_out  out : result n (0 for value 0)
//   exact  out : n_out! == value
//   err    out : value was 0
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module inverse_factorial #(
    parameter int VAL_W = fact_pkg::VAL_W,
    parameter int MAX_N = fact_pkg::FACT_MAX_N
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [VAL_W-1:0]         value,
    output logic                     busy,
    output logic                     done,
    output logic [fact_pkg::N_W-1:0] n_out,
    output logic                     exact,
    output logic                     err
);

    import fact_pkg::*;

    state_t              state_q, state_d;
    logic [VAL_W-1:0]    value_q, value_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [N_W-1:0]      k_q, k_d;
    logic [N_W-1:0]      n_out_q, n_out_d;
    logic                exact_q, exact_d;
    logic                err_q, err_d;

    logic [PROD_W-1:0]   prod;
    logic                advance;

    fact_step #(
        .MAX_N (MAX_N)
    ) u_step (
        .acc     (acc_q),
        .k       (k_q),
        .value   (value_q),
        .prod    (prod),
        .advance (advance)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            value_q <= '0;
            acc_q   <= PROD_W'(1);
            k_q     <= N_W'(1);
            n_out_q <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            n_out_q <= n_out_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    // Result registers only change on entry to DONE, so they hold the last
    // answer through IDLE and the whole of the next search.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        acc_d   = acc_q;
        k_d     = k_q;
        n_out_d = n_out_q;
        exact_d = exact_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = value;
                    acc_d   = PROD_W'(1);
                    k_d     = N_W'(1);
                    if (value == '0) begin
                        // 0 has no n with n! <= 0; report it without searching.
                        state_d = DONE;
                        n_out_d = '0;
                        exact_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (advance) begin
                    acc_d = prod;
                    k_d   = k_q + N_W'(1);
                end else begin
                    state_d = DONE;
                    n_out_d = k_q;
                    exact_d = (acc_q == PROD_W'(value_q));
                    err_d   = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q == CALC);
    assign done  = (state_q == DONE);
    assign n_out = n_out_q;
    assign exact = exact_q;
    assign err   = err_q;

endmodule

// File: tb/tb_inverse_factorial.sv
// ---------------------------------------------------------------------------
// tb_inverse_factorial
// Directed bench for inverse_factorial. Each accepted request pushes the
// expected result (from a factorial table) onto a scoreboard queue; each done
// pulse pops one entry and compares n_out/exact/err, latency and busy time.
// ---------------------------------------------------------------------------
module tb_inverse_factorial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  n_out;
    logic        exact;
    logic        err;

    typedef struct {
        int n;
        int exact;
        int err;
        int latency;
        int acceptCycle;
    } expect_t;

    expect_t sbQueue[$];

    int checks     = 0;
    int errors     = 0;
    int cycleCount = 0;
    int heldBase   = 0;
    int factTab [9] = '{1, 1, 2, 6, 24, 120, 720, 5040, 40320};

    inverse_factorial #(
        .VAL_W (16),
        .MAX_N (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .exact (exact),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Expected result for a request accepted on the edge that brings
    // cycleCount to acceptCycle. A nonzero value spends n cycles in CALC;
    // value 0 skips CALC, so DONE follows the accepting edge immediately.
    function automatic expect_t modelResult(input int v, input int acceptCycle);
        expect_t r;
        r.acceptCycle = acceptCycle;
        if (v == 0) begin
            r.n       = 0;
            r.exact   = 0;
            r.err     = 1;
            r.latency = 0;
        end else begin
            r.n = 1;
            for (int i = 2; i <= 8; i++) begin
                if (factTab[i] <= v) r.n = i;
            end
            r.exact   = (factTab[r.n] == v) ? 1 : 0;
            r.err     = 0;
            r.latency = r.n;
        end
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at 1ns after a rising edge with the DUT in IDLE; the request is
    // accepted on the next edge.
    task automatic applyStimulus(input int v, input bit hold);
        sbQueue.push_back(modelResult(v, cycleCount + 1));
        start = 1'b1;
        value = v[15:0];
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic checkOutput(input bit checkBusy);
        expect_t e;
        int      waited  = 0;
        int      busyCnt = 0;
        bit      seen    = 0;
        while (waited < 40 && !seen) begin
            @(negedge clk);
            waited++;
            if (done) seen = 1;
            else if (busy) busyCnt++;
        end
        checkValue("done_seen", 32'(seen), 32'd1);
        if (sbQueue.size() == 0) begin
            checkValue("scoreboard_entry", 32'(sbQueue.size()), 32'd1);
        end else begin
            e = sbQueue.pop_front();
            if (seen) begin
                checkValue("latency", 32'(cycleCount - e.acceptCycle), 32'(e.latency));
                checkValue("n_out", 32'(n_out), 32'(e.n));
                checkValue("exact", 32'(exact), 32'(e.exact));
                checkValue("err", 32'(err), 32'(e.err));
                checkValue("busy_in_done", 32'(busy), 32'd0);
                if (checkBusy) checkValue("busy_cycles", 32'(busyCnt), 32'(e.n));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkNoDone(input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkValue("no_extra_done", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("rst_busy", 32'(busy), 32'd0);
        checkValue("rst_done", 32'(done), 32'd0);
        checkValue("rst_n_out", 32'(n_out), 32'd0);
        checkValue("rst_exact", 32'(exact), 32'd0);
        checkValue("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(120, 0);   checkOutput(1);
        applyStimulus(121, 0);   checkOutput(1);
        applyStimulus(719, 0);   checkOutput(1);
        applyStimulus(720, 0);   checkOutput(1);
        applyStimulus(0, 0);     checkOutput(1);
        applyStimulus(1, 0);     checkOutput(1);
        applyStimulus(40320, 0); checkOutput(1);
        applyStimulus(65535, 0); checkOutput(1);

        // A second request mid-CALC, with value changing too, is dropped.
        applyStimulus(24, 0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        value = 16'd720;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput(0);
        checkNoDone(12);
        checkValue("n_out_hold", 32'(n_out), 32'd4);
        checkValue("exact_hold", 32'(exact), 32'd1);

        // start held high: the second request goes in on the edge that ends
        // the IDLE cycle after DONE (first accept + 3 CALC + DONE + IDLE).
        heldBase = cycleCount;
        applyStimulus(6, 1);
        checkOutput(1);
        value = 16'd24;
        sbQueue.push_back(modelResult(24, heldBase + 1 + 3 + 2));
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput(1);

        // Reset on the third CALC cycle aborts; start during reset is ignored.
        applyStimulus(5040, 0);
        sbQueue.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        value = 16'd720;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkValue("abort_busy", 32'(busy), 32'd0);
        checkValue("abort_done", 32'(done), 32'd0);
        checkValue("abort_n_out", 32'(n_out), 32'd0);
        checkValue("abort_exact", 32'(exact), 32'd0);
        checkValue("abort_err", 32'(err), 32'd0);
        checkNoDone(12);
        applyStimulus(6, 0);
        checkOutput(1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(int'($urandom_range(2, 65535)), 0);
            checkOutput(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
